serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder. Sits directly upstream of the existing
//   1-bit fulladder cell: latches two operands plus carry-in, then feeds one
//   bit pair per clock (LSB first) into a single fulladder instance.
//   The carry is registered between bits and the sum is shifted into a result register.
//   Trades WIDTH cycles of latency for one adder cell. Parallel-load, parallel-read datapath front end.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range >= 2
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  operand A, captured on the accepting edge
//   b       in   WIDTH  operand B, captured on the accepting edge
//   cin     in   1      carry-in, captured on the accepting edge
//   busy    out  1      1 while bits are being added (state SHIFT)
//   done    out  1      one-cycle pulse: sum/cout hold the new result
//   sum     out  WIDTH  result, registered; holds until the next completion
//   cout    out  1      final carry-out, registered; same hold rule as sum
// BEHAVIOUR
//   Reset: rst_n=0 forces state IDLE immediately, without waiting for a clock edge.
//     It also clears busy, done, sum, cout, the shift registers, the carry flop and the bit counter to 0.
//   FSM states IDLE, SHIFT, DONE. Encoding is free.
//   IDLE:  start=1 at an edge -> load a_sr<=a, b_sr<=b, c<=cin, cnt<=0 -> SHIFT.
//          start=0 -> stay in IDLE.
//   SHIFT: every edge, drive fulladder inputs: a=a_sr[0], b=b_sr[0], cin=c.
//          Then:
//          - s_sr <= {fa.sum, s_sr[WIDTH-1:1]} (the sum bit enters at the MSB)
//          - c <= fa.carry
//          - a_sr and b_sr shift right by 1
//          - cnt <= cnt+1
//          When cnt==WIDTH-1 on that edge -> sum<=final s_sr, cout<=fa.carry, go to DONE.
//   DONE:  done=1 for exactly this one cycle -> IDLE unconditionally.
//   Latency: accepting edge E0; the bits are processed on edges E1..EWIDTH.
//     sum/cout/done become valid after EWIDTH.
//     The back-to-back issue interval is WIDTH+2 cycles.
//   busy = (state==SHIFT). done = (state==DONE). Both are registered-state decodes.
//   start while SHIFT or DONE: ignored. No queueing, and the operands are not re-sampled.
//   a/b/cin may change freely after the accepting edge.
//   Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned.
//     Overflow shows up only as cout.
//   cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1.
//   Reset during SHIFT or DONE: the partial result is discarded.
//     The previous sum/cout are also cleared to 0.
//     The first start after rst_n rises behaves as from power-up.
//   The sum/cout output registers change only on the SHIFT->DONE transition.
// TESTING (WIDTH=8)
//   a=0x0F b=0x01 cin=0, start 1 cycle -> busy for 8 cycles; done pulse at
//     cycle 9 after the accepting edge; sum=0x10 cout=0
//   a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 (full carry ripple and wrap)
//   a=0xFF b=0xFF cin=1 -> sum=0xFF cout=1. a=0 b=0 cin=0 -> sum=0x00 cout=0
//   start with a=0x12 b=0x34; re-pulse start with a=0xAA b=0x55 on the 3rd
//     busy cycle -> second request is ignored; sum=0x46 cout=0; one done pulse only
//   rst_n low on the 4th SHIFT cycle (asynchronous, mid-clock) -> busy/done/sum/cout=0
//     immediately. After release, a=0x80 b=0x80 -> sum=0x00 cout=1
//   start held high continuously with a=0x01 b=0x01 -> done pulses every 10
//     cycles; sum=0x02 each time; busy is low for exactly 2 cycles between ops

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built around one fulladder cell

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    fulladder u_fa (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .cin   (r_c),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);
    // Sum bits arrive LSB first, so each new bit enters at the top and walks down.
    assign w_s_next = {w_fa_sum, r_s_sr[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; DONE always lasts exactly one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand load, per-bit shifting and the carry flop between bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_s_sr <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_c    <= cin;
            r_cnt  <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_s_sr <= w_s_next;
            r_c    <= w_fa_carry;
            // Wrap explicitly so the counter stays within 0..WIDTH-1 for any WIDTH.
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Result registers only move on the final bit, so they hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_s_next;
            r_cout <= w_fa_carry;
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int errors = 0;
    int checks = 0;
    logic [8:0] last_result = '0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned addition, 9-bit result {cout,sum}.
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Issues one request and observes 12 cycles after the accepting edge.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output int busy_n, output int done_at, output int pulses,
                         output logic [8:0] res, output logic [8:0] mid_res);
        busy_n = 0; done_at = -1; pulses = 0; res = '0; mid_res = '0;
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (k == 4) mid_res = {cout, sum};
            if (done) begin
                pulses++;
                done_at = k;
                res = {cout, sum};
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] va [4] = '{8'h0F, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] vb [4] = '{8'h01, 8'h01, 8'hFF, 8'h00};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int bn, da, pn;
        logic [8:0] res, mid, exp;
        for (int i = 0; i < 4; i++) begin
            exp = ref_add(va[i], vb[i], vc[i]);
            do_op(va[i], vb[i], vc[i], bn, da, pn, res, mid);
            checks++; if (res !== exp) begin errors++; $display("FAIL basic%0d_result got=%h exp=%h", i, res, exp); end
            checks++; if (bn != 8) begin errors++; $display("FAIL basic%0d_busy_cycles got=%0d exp=8", i, bn); end
            checks++; if (da != 9) begin errors++; $display("FAIL basic%0d_done_cycle got=%0d exp=9", i, da); end
            checks++; if (pn != 1) begin errors++; $display("FAIL basic%0d_done_pulses got=%0d exp=1", i, pn); end
            checks++; if (mid !== last_result) begin errors++; $display("FAIL basic%0d_sum_hold got=%h exp=%h", i, mid, last_result); end
            last_result = exp;
        end
    endtask

    task automatic test_random;
        int bn, da, pn;
        logic [8:0] res, mid, exp;
        logic [7:0] ra, rb;
        logic rc;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = ref_add(ra, rb, rc);
            do_op(ra, rb, rc, bn, da, pn, res, mid);
            checks++; if (res !== exp || da != 9) begin
                errors++; $display("FAIL random%0d a=%h b=%h cin=%b got=%h@%0d exp=%h@9", i, ra, rb, rc, res, da, exp);
            end
            checks++; if (mid !== last_result) begin errors++; $display("FAIL random%0d_sum_hold got=%h exp=%h", i, mid, last_result); end
            last_result = exp;
        end
    endtask

    task automatic test_ignore_start;
        int pulses = 0;
        logic [8:0] res = '0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin pulses++; res = {cout, sum}; end
            if (k == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
            if (k == 4) start = 1'b0;
        end
        checks++; if (res !== 9'h046) begin errors++; $display("FAIL ignore_start_result got=%h exp=046", res); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_start_pulses got=%0d exp=1", pulses); end
        last_result = 9'h046;
    endtask

    task automatic test_reset_mid;
        int bn, da, pn;
        logic [8:0] res, mid;
        @(negedge clk);
        a = 8'h5A; b = 8'h21; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b exp=0,0", busy, done); end
        checks++; if ({cout, sum} !== 9'h000) begin errors++; $display("FAIL midreset_result got=%h exp=000", {cout, sum}); end
        @(negedge clk);
        rst_n = 1'b1;
        last_result = 9'h000;
        do_op(8'h80, 8'h80, 1'b0, bn, da, pn, res, mid);
        checks++; if (res !== 9'h100 || da != 9) begin errors++; $display("FAIL post_reset_op got=%h@%0d exp=100@9", res, da); end
        last_result = 9'h100;
    endtask

    task automatic test_back_to_back;
        logic bz [40];
        logic dn [40];
        logic [8:0] rs [40];
        int dpos [$];
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bz[k] = busy; dn[k] = done; rs[k] = {cout, sum};
            if (done) dpos.push_back(k);
        end
        start = 1'b0;
        checks++; if (dpos.size() < 3) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp>=3", dpos.size()); end
        for (int i = 0; i < dpos.size(); i++) begin
            checks++; if (rs[dpos[i]] !== 9'h002) begin errors++; $display("FAIL b2b_result%0d got=%h exp=002", i, rs[dpos[i]]); end
            if (i > 0) begin
                checks++; if (dpos[i] - dpos[i-1] != 10) begin errors++; $display("FAIL b2b_interval%0d got=%0d exp=10", i, dpos[i] - dpos[i-1]); end
            end
            if (dpos[i] >= 1 && dpos[i] + 2 < 40) begin
                checks++;
                if (bz[dpos[i]-1] !== 1'b1 || bz[dpos[i]] !== 1'b0 || bz[dpos[i]+1] !== 1'b0 || bz[dpos[i]+2] !== 1'b1) begin
                    errors++; $display("FAIL b2b_busy_gap%0d got=%b%b%b%b exp=1001", i, bz[dpos[i]-1], bz[dpos[i]], bz[dpos[i]+1], bz[dpos[i]+2]);
                end
            end
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
